// File: rtl/vga_box_renderer_if.sv
// Shape-position bus between the movement FSM (master) and the box renderer (slave).
// Position and size are sampled once per frame by the renderer; colours are used live.
interface vga_box_renderer_if;
    logic [9:0]  shapeX;
    logic [9:0]  shapeY;
    logic [9:0]  shapeSize;
    logic [11:0] fillColor;
    logic [11:0] borderColor;

    modport master (output shapeX, shapeY, shapeSize, fillColor, borderColor);
    modport slave  (input  shapeX, shapeY, shapeSize, fillColor, borderColor);
endinterface

// File: rtl/vga_box_renderer.sv
// VGA timing generator and single-box renderer: pixel-tick divider, raster counters,
// per-frame shape latch and one registered output stage shared by sync, RGB and counts.
module vga_box_renderer #(
    parameter int          CLK_DIV  = 4,
    parameter int          H_VIS    = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_VIS    = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter int          BORDER   = 2,
    parameter logic [11:0] BG_COLOR = 12'h000,
    parameter logic [9:0]  DEF_X    = 10'd290,
    parameter logic [9:0]  DEF_Y    = 10'd210,
    parameter logic [9:0]  DEF_SIZE = 10'd60
) (
    input  logic              iClk,
    input  logic              iRst,
    vga_box_renderer_if.slave shapeBus,
    output logic              oHS,
    output logic              oVS,
    output logic [3:0]        oRed,
    output logic [3:0]        oGreen,
    output logic [3:0]        oBlue,
    output logic [9:0]        oHCount,
    output logic [9:0]        oVCount,
    output logic              oFrameStart
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS_END  = 10'(H_VIS);
    localparam logic [9:0]  V_VIS_END  = 10'(V_VIS);
    localparam logic [9:0]  H_SYNC_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0]  H_SYNC_END = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  V_SYNC_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0]  V_SYNC_END = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [10:0] BORDER_W   = 11'(BORDER);

    function automatic logic [11:0] pickColor(
        input logic        visible,
        input logic        inBox,
        input logic        onBorder,
        input logic [11:0] fill,
        input logic [11:0] edgeColor
    );
        if (!visible)
            return 12'h000;
        else if (onBorder)
            return edgeColor;
        else if (inBox)
            return fill;
        else
            return BG_COLOR;
    endfunction

    logic [DIV_W-1:0] divCnt;
    logic             vld_p0;
    logic [9:0]       hCnt_p0;
    logic [9:0]       vCnt_p0;
    logic [9:0]       boxX;
    logic [9:0]       boxY;
    logic [9:0]       boxSize;

    logic [10:0]      h11, v11, xLo, xHi, yLo, yHi;
    logic             visible, inBox, onBorder;
    logic [11:0]      pixColor;

    logic             hs_p1, vs_p1, frameStart_p1;
    logic [11:0]      rgb_p1;
    logic [9:0]       hCount_p1, vCount_p1;

    assign vld_p0 = (divCnt == DIV_LAST);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)
            divCnt <= '0;
        else if (vld_p0)
            divCnt <= '0;
        else
            divCnt <= divCnt + DIV_W'(1);
    end

    // Stage p0: raster counters; the shape is latched on the last pixel of each frame.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            hCnt_p0 <= '0;
            vCnt_p0 <= '0;
            boxX    <= DEF_X;
            boxY    <= DEF_Y;
            boxSize <= DEF_SIZE;
        end else if (vld_p0) begin
            if (hCnt_p0 == H_LAST) begin
                hCnt_p0 <= '0;
                vCnt_p0 <= (vCnt_p0 == V_LAST) ? 10'd0 : vCnt_p0 + 10'd1;
            end else begin
                hCnt_p0 <= hCnt_p0 + 10'd1;
            end
            if (hCnt_p0 == H_LAST && vCnt_p0 == V_LAST) begin
                boxX    <= shapeBus.shapeX;
                boxY    <= shapeBus.shapeY;
                boxSize <= shapeBus.shapeSize;
            end
        end
    end

    // 11-bit edges so X+S never wraps back onto low columns/rows.
    assign h11      = {1'b0, hCnt_p0};
    assign v11      = {1'b0, vCnt_p0};
    assign xLo      = {1'b0, boxX};
    assign yLo      = {1'b0, boxY};
    assign xHi      = xLo + {1'b0, boxSize};
    assign yHi      = yLo + {1'b0, boxSize};
    assign visible  = (hCnt_p0 < H_VIS_END) && (vCnt_p0 < V_VIS_END);
    assign inBox    = (h11 >= xLo) && (h11 < xHi) && (v11 >= yLo) && (v11 < yHi);
    assign onBorder = inBox && ((h11 < xLo + BORDER_W) || (h11 >= xHi - BORDER_W) ||
                                (v11 < yLo + BORDER_W) || (v11 >= yHi - BORDER_W));
    assign pixColor = pickColor(visible, inBox, onBorder,
                                shapeBus.fillColor, shapeBus.borderColor);

    // Stage p1: every output registered from the same pre-increment counter values.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            hs_p1         <= 1'b1;
            vs_p1         <= 1'b1;
            rgb_p1        <= '0;
            hCount_p1     <= '0;
            vCount_p1     <= '0;
            frameStart_p1 <= 1'b0;
        end else begin
            frameStart_p1 <= vld_p0 && (hCnt_p0 == 10'd0) && (vCnt_p0 == 10'd0);
            if (vld_p0) begin
                hs_p1     <= !((hCnt_p0 >= H_SYNC_BEG) && (hCnt_p0 < H_SYNC_END));
                vs_p1     <= !((vCnt_p0 >= V_SYNC_BEG) && (vCnt_p0 < V_SYNC_END));
                rgb_p1    <= pixColor;
                hCount_p1 <= hCnt_p0;
                vCount_p1 <= vCnt_p0;
            end
        end
    end

    assign oHS         = hs_p1;
    assign oVS         = vs_p1;
    assign oRed        = rgb_p1[11:8];
    assign oGreen      = rgb_p1[7:4];
    assign oBlue       = rgb_p1[3:0];
    assign oHCount     = hCount_p1;
    assign oVCount     = vCount_p1;
    assign oFrameStart = frameStart_p1;
endmodule
